// File: rtl/ara_resp_sync.sv
// Merges one response per Ara cluster into a single response toward CVA6.
// Each cluster is latched once per round; the merged result drains when every cluster has reported.
module ara_resp_sync #(
    parameter int unsigned NrClusters    = 4,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned IdWidth       = 3,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NrClusters-1:0]           resp_valid_i,
    output logic [NrClusters-1:0]           resp_ready_o,
    input  logic [NrClusters*DataWidth-1:0] resp_result_i,
    input  logic [NrClusters-1:0]           resp_exc_i,
    input  logic [NrClusters*IdWidth-1:0]   resp_trans_id_i,
    output logic                            resp_valid_o,
    input  logic                            resp_ready_i,
    output logic [DataWidth-1:0]            resp_result_o,
    output logic                            resp_exc_o,
    output logic [IdWidth-1:0]              resp_trans_id_o,
    output logic                            id_mismatch_o,
    output logic                            timeout_o
);

    localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);

    typedef enum logic {
        COLLECT,
        DRAIN
    } state_e;

    state_e                  state_reg, state_next;
    logic [NrClusters-1:0]   full_reg, full_next;
    logic [NrClusters-1:0]   capture;
    logic [DataWidth-1:0]    result_reg [NrClusters];
    logic [IdWidth-1:0]      id_reg     [NrClusters];
    logic [IdWidth-1:0]      id_next    [NrClusters];
    logic [NrClusters-1:0]   exc_reg;
    logic [CntWidth-1:0]     cnt_reg, cnt_next;
    logic                    timeout_reg, timeout_next;
    logic                    mismatch_reg, mismatch_next;
    logic                    enter_drain;
    logic                    partial;
    logic                    id_diff;

    // A cluster is accepted only while its slot is empty, so each round takes exactly one beat per cluster.
    for (genvar gi = 0; gi < NrClusters; gi++) begin : g_cluster
        assign capture[gi] = resp_valid_i[gi] & ~full_reg[gi];
        assign id_next[gi] = capture[gi] ? resp_trans_id_i[gi*IdWidth +: IdWidth] : id_reg[gi];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NrClusters; c++) begin
                result_reg[c] <= '0;
                id_reg[c]     <= '0;
            end
            exc_reg <= '0;
        end else begin
            for (int c = 0; c < NrClusters; c++) begin
                if (capture[c]) begin
                    result_reg[c] <= resp_result_i[c*DataWidth +: DataWidth];
                    id_reg[c]     <= id_next[c];
                    exc_reg[c]    <= resp_exc_i[c];
                end
            end
        end
    end

    // Compare against the ids as they will look once this cycle's captures land.
    always_comb begin
        id_diff = 1'b0;
        for (int c = 1; c < NrClusters; c++) begin
            if (id_next[c] != id_next[0]) begin
                id_diff = 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        full_next   = full_reg | capture;
        enter_drain = 1'b0;
        unique case (state_reg)
            COLLECT: begin
                if (&(full_reg | capture)) begin
                    state_next  = DRAIN;
                    enter_drain = 1'b1;
                end
            end
            DRAIN: begin
                if (resp_ready_i) begin
                    state_next = COLLECT;
                    full_next  = '0;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // Watchdog: counts cycles a partial round stays open, saturating so the flag cannot be missed.
    assign partial = (|full_reg) & ~(&full_reg);

    always_comb begin
        cnt_next = '0;
        if ((state_reg == COLLECT) && !enter_drain && partial) begin
            cnt_next = (cnt_reg == CntWidth'(TimeoutCycles)) ? cnt_reg : cnt_reg + CntWidth'(1);
        end
    end

    assign timeout_next  = timeout_reg | (cnt_next == CntWidth'(TimeoutCycles));
    assign mismatch_next = enter_drain & id_diff;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= COLLECT;
            full_reg     <= '0;
            cnt_reg      <= '0;
            timeout_reg  <= 1'b0;
            mismatch_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            full_reg     <= full_next;
            cnt_reg      <= cnt_next;
            timeout_reg  <= timeout_next;
            mismatch_reg <= mismatch_next;
        end
    end

    assign resp_ready_o    = ~full_reg;
    assign resp_valid_o    = (state_reg == DRAIN);
    assign resp_result_o   = result_reg[0];
    assign resp_trans_id_o = id_reg[0];
    assign resp_exc_o      = |exc_reg;
    assign id_mismatch_o   = mismatch_reg;
    assign timeout_o       = timeout_reg;

endmodule
